// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - format/opcode constants and request bundle for the instruction encoder
package inst_encoder_pkg;

   // Format codes are shared with the immediate generator; keep values in lockstep.
   localparam logic [2:0] FMT_R     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_I     = 3'd5;
   localparam logic [2:0] FMT_ISTAR = 3'd6;
   localparam logic [2:0] FMT_ILL   = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_OP_IMM = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   function automatic logic in_range(input logic [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational immediate range checker and RV32I field packer
module inst_pack
   import inst_encoder_pkg::*;
(
   input  logic [2:0]  chk_fmt,
   input  logic [31:0] chk_imm,
   output logic        chk_err,
   input  enc_req_t    req,
   output logic [31:0] inst
);

   always_comb begin
      chk_err = 1'b0;
      case (chk_fmt)
         FMT_R:        chk_err = 1'b0;
         FMT_I, FMT_S: chk_err = !in_range(chk_imm, -32'sd2048, 32'sd2047);
         FMT_B:        chk_err = !in_range(chk_imm, -32'sd4096, 32'sd4094) || chk_imm[0];
         FMT_J:        chk_err = !in_range(chk_imm, -32'sd1048576, 32'sd1048574) || chk_imm[0];
         FMT_U:        chk_err = |chk_imm[11:0];
         FMT_ISTAR:    chk_err = |chk_imm[31:5];
         default:      chk_err = 1'b1;
      endcase
   end

   // Out-of-range immediates are simply truncated into the available bits.
   always_comb begin
      inst = '0;
      case (req.fmt)
         FMT_R:
            inst = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
         FMT_I:
            inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
         FMT_ISTAR:
            inst = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
         FMT_S:
            inst = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
         FMT_B:
            inst = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                    req.imm[4:1], req.imm[11], req.opcode};
         FMT_U:
            inst = {req.imm[31:12], req.rd, req.opcode};
         FMT_J:
            inst = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                    req.rd, req.opcode};
         default:
            inst = '0;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage valid/ready RV32I instruction encoder with delivery counters
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   enc_req_t    in_req;
   enc_req_t    s1_req;
   logic        s1_valid;
   logic        s1_err;
   logic        s2_valid;
   logic        chk_err;
   logic [31:0] packed_inst;
   logic        s1_adv;
   logic        s2_adv;

   always_comb begin
      in_req.fmt    = in_fmt;
      in_req.opcode = in_opcode;
      in_req.rd     = in_rd;
      in_req.funct3 = in_funct3;
      in_req.rs1    = in_rs1;
      in_req.rs2    = in_rs2;
      in_req.funct7 = in_funct7;
      in_req.imm    = in_imm;
   end

   // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   inst_pack u_pack (
      .chk_fmt (in_fmt),
      .chk_imm (in_imm),
      .chk_err (chk_err),
      .req     (s1_req),
      .inst    (packed_inst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
         s1_err   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_req <= in_req;
            s1_err <= chk_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_inst <= '0;
         out_err  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_inst <= packed_inst;
            out_err  <= s1_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_valid && out_ready) begin
         enc_count <= enc_count + 1'b1;
         if (out_err) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
